// File: rtl/fas_seq.sv
// fas_seq: run sequencer for the FIR/FFT (FAS) pipeline.
// Feeds upstream samples into the pipeline and tracks frame completion for each run.
module fas_seq #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  num_frames,
  input  logic        src_valid,
  input  logic [15:0] src_data,
  output logic        src_ready,
  output logic        data_valid,
  output logic [15:0] data,
  input  logic        fir_valid,
  input  logic        fft_valid,
  input  logic        done,
  input  logic [3:0]  freq,
  output logic        busy,
  output logic [7:0]  frames_done,
  output logic [3:0]  freq_out,
  output logic        freq_valid,
  output logic        all_done,
  output logic        err
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned FREQ_W = 4;
  localparam int unsigned FL_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FL_W-1:0]  FL_LAST = FL_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LIM  = (TIMEOUT > 255) ? CNT_MAX : CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  num_q, num_d;
  logic [FL_W-1:0]   fir_cnt_q, fir_cnt_d;
  logic [CNT_W-1:0]  fir_frames_q, fir_frames_d;
  logic [CNT_W-1:0]  frames_done_q, frames_done_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic              data_valid_q, data_valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [FREQ_W-1:0] freq_out_q, freq_out_d;
  logic              freq_valid_q, freq_valid_d;
  logic              busy_q, busy_d;
  logic              all_done_q, all_done_d;
  logic              err_q, err_d;

  logic              launch_c;
  logic              run_c;
  logic              accept_c;
  logic              timeout_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Abort drops the handshake in the same cycle it is raised.
  assign src_ready = (state_q == STREAM) && !abort;

  assign launch_c = (state_q == IDLE) && start;
  assign run_c    = ((state_q == STREAM) || (state_q == DRAIN)) && !abort;
  assign accept_c = src_valid && src_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state; busy/all_done are registered copies of the next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_frames == '0) ? FINISH : STREAM;
        end
      end
      STREAM: begin
        if (abort || timeout_c) begin
          state_d = IDLE;
        end else if (fir_frames_d >= num_q) begin
          state_d = (frames_done_d >= num_q) ? FINISH : DRAIN;
        end
      end
      DRAIN: begin
        if (abort || timeout_c) begin
          state_d = IDLE;
        end else if (frames_done_d >= num_q) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d     = (state_d != IDLE);
    all_done_d = (state_d == FINISH);
  end

  // Counters, sample path and result capture
  always_comb begin
    num_d         = num_q;
    fir_cnt_d     = fir_cnt_q;
    fir_frames_d  = fir_frames_q;
    frames_done_d = frames_done_q;
    idle_d        = idle_q;
    data_d        = data_q;
    data_valid_d  = accept_c;
    freq_out_d    = freq_out_q;
    freq_valid_d  = 1'b0;
    err_d         = err_q;
    timeout_c     = 1'b0;

    if (accept_c) begin
      data_d = src_data;
    end

    if (launch_c) begin
      num_d         = num_frames;
      fir_cnt_d     = '0;
      fir_frames_d  = '0;
      frames_done_d = '0;
      idle_d        = '0;
      err_d         = 1'b0;
    end else if (run_c) begin
      if (fir_valid) begin
        fir_cnt_d = (fir_cnt_q == FL_LAST) ? '0 : fir_cnt_q + FL_W'(1);
        if (fir_cnt_q == FL_LAST) begin
          fir_frames_d = sat_inc(fir_frames_q);
        end
      end
      if (done) begin
        frames_done_d = sat_inc(frames_done_q);
        freq_out_d    = freq;
        freq_valid_d  = 1'b1;
      end
      // Any pipeline strobe (fft_valid included) counts as activity
      if (fir_valid || done || fft_valid) begin
        idle_d = '0;
      end else begin
        idle_d = sat_inc(idle_q);
      end
      if (idle_d >= TO_LIM) begin
        timeout_c = 1'b1;
        err_d     = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_q         <= '0;
      fir_cnt_q     <= '0;
      fir_frames_q  <= '0;
      frames_done_q <= '0;
      idle_q        <= '0;
      data_valid_q  <= 1'b0;
      data_q        <= '0;
      freq_out_q    <= '0;
      freq_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      all_done_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      num_q         <= num_d;
      fir_cnt_q     <= fir_cnt_d;
      fir_frames_q  <= fir_frames_d;
      frames_done_q <= frames_done_d;
      idle_q        <= idle_d;
      data_valid_q  <= data_valid_d;
      data_q        <= data_d;
      freq_out_q    <= freq_out_d;
      freq_valid_q  <= freq_valid_d;
      busy_q        <= busy_d;
      all_done_q    <= all_done_d;
      err_q         <= err_d;
    end
  end

  assign data_valid  = data_valid_q;
  assign data        = data_q;
  assign busy        = busy_q;
  assign frames_done = frames_done_q;
  assign freq_out    = freq_out_q;
  assign freq_valid  = freq_valid_q;
  assign all_done    = all_done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fas_seq.sv
// tb_fas_seq: directed scenarios plus random traffic for fas_seq, checked every
// cycle against a count-based reference model held in the bench.
module tb_fas_seq;

  localparam int unsigned FL = 16;
  localparam int unsigned TO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  num_frames = '0;
  logic        src_valid = 1'b0;
  logic [15:0] src_data = '0;
  logic        src_ready;
  logic        data_valid;
  logic [15:0] data;
  logic        fir_valid = 1'b0;
  logic        fft_valid = 1'b0;
  logic        done = 1'b0;
  logic [3:0]  freq = '0;
  logic        busy;
  logic [7:0]  frames_done;
  logic [3:0]  freq_out;
  logic        freq_valid;
  logic        all_done;
  logic        err;

  always #5 clk = ~clk;

  fas_seq #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_frames(num_frames),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .data_valid(data_valid), .data(data), .fir_valid(fir_valid), .fft_valid(fft_valid),
    .done(done), .freq(freq), .busy(busy), .frames_done(frames_done),
    .freq_out(freq_out), .freq_valid(freq_valid), .all_done(all_done), .err(err)
  );

  int nvec = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  // Reference model: run phase plus raw event totals; frame counts derived arithmetically.
  int          m_phase = 0;   // 0 idle, 1 stream, 2 drain, 3 finish
  int          m_num = 0;
  int          m_fir_total = 0;
  int          m_done_total = 0;
  int          m_idle_run = 0;
  logic        m_err = 1'b0;
  logic        m_fv = 1'b0;
  logic        m_dv = 1'b0;
  logic [3:0]  m_freq = '0;
  logic [15:0] m_data = '0;

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_num = 0; m_fir_total = 0; m_done_total = 0; m_idle_run = 0;
      m_err = 1'b0; m_fv = 1'b0; m_dv = 1'b0; m_freq = '0; m_data = '0;
    end else begin
      m_dv = (m_phase == 1) && !abort && src_valid;
      if (m_dv) m_data = src_data;
      m_fv = 1'b0;
      if (m_phase == 0) begin
        if (start) begin
          m_num = int'(num_frames);
          m_fir_total = 0; m_done_total = 0; m_idle_run = 0; m_err = 1'b0;
          m_phase = (num_frames == 0) ? 3 : 1;
        end
      end else if (m_phase == 3 || abort) begin
        m_phase = 0;
      end else begin
        if (fir_valid) m_fir_total++;
        if (done) begin
          m_done_total++;
          m_freq = freq;
          m_fv = 1'b1;
        end
        if (fir_valid || done || fft_valid) m_idle_run = 0;
        else m_idle_run++;
        if (m_idle_run >= int'(TO)) begin
          m_err = 1'b1;
          m_phase = 0;
        end else if (m_phase == 1 && sat255(m_fir_total / int'(FL)) >= m_num) begin
          m_phase = (sat255(m_done_total) >= m_num) ? 3 : 2;
        end else if (m_phase == 2 && sat255(m_done_total) >= m_num) begin
          m_phase = 3;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    chk(nm, act, exp);
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      nvec++;
      chk("busy",        32'(busy),        32'(m_phase != 0));
      chk("src_ready",   32'(src_ready),   32'((m_phase == 1) && !abort));
      chk("data_valid",  32'(data_valid),  32'(m_dv));
      chk("data",        32'(data),        32'(m_data));
      chk("frames_done", 32'(frames_done), 32'(sat255(m_done_total)));
      chk("freq_out",    32'(freq_out),    32'(m_freq));
      chk("freq_valid",  32'(freq_valid),  32'(m_fv));
      chk("all_done",    32'(all_done),    32'(m_phase == 3));
      chk("err",         32'(err),         32'(m_err));
    end
  end

  int n_ad = 0;
  logic [3:0] fq[$];
  always @(negedge clk) begin
    if (all_done) n_ad++;
    if (freq_valid) fq.push_back(freq_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; abort = 1'b0; src_valid = 1'b0;
    fir_valid = 1'b0; fft_valid = 1'b0; done = 1'b0;
  endtask

  task automatic launch(input logic [7:0] n);
    num_frames = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] sent;
    logic        sv;
    int          k;

    idle_in();
    repeat (3) tick();
    chk_en = 1'b1;
    lit("rst_busy", 32'(busy), 0);
    lit("rst_frames_done", 32'(frames_done), 0);
    lit("rst_data_valid", 32'(data_valid), 0);
    lit("rst_err", 32'(err), 0);
    rst = 1'b1;
    tick(); tick();

    // Two frames, results 5 then 9
    n_ad = 0; fq.delete();
    launch(8'd2);
    lit("s1_busy", 32'(busy), 1);
    for (int i = 0; i < 34; i++) begin
      src_valid = 1'b1; src_data = 16'($urandom);
      fir_valid = (i < 32);
      done = (i == 20) || (i == 33);
      freq = (i == 20) ? 4'd5 : 4'd9;
      tick();
    end
    idle_in();
    tick(); tick();
    lit("s1_all_done_cnt", 32'(n_ad), 1);
    lit("s1_fv_cnt", 32'(fq.size()), 2);
    if (fq.size() == 2) begin
      lit("s1_freq0", 32'(fq[0]), 5);
      lit("s1_freq1", 32'(fq[1]), 9);
    end
    lit("s1_frames_done", 32'(frames_done), 2);
    lit("s1_busy_after", 32'(busy), 0);
    done = 1'b1; freq = 4'd3;
    tick();
    done = 1'b0;
    tick();
    lit("idle_done_ignored", 32'(frames_done), 2);
    lit("idle_done_fv", 32'(fq.size()), 2);

    // Zero-frame run
    launch(8'd0);
    src_valid = 1'b1;
    lit("s2_all_done", 32'(all_done), 1);
    lit("s2_src_ready", 32'(src_ready), 0);
    tick();
    src_valid = 1'b0;
    lit("s2_all_done_off", 32'(all_done), 0);
    lit("s2_busy", 32'(busy), 0);

    // Alternating src_valid
    launch(8'd1);
    for (int i = 0; i < 12; i++) begin
      src_valid = (i % 2 == 0); src_data = 16'($urandom); fir_valid = 1'b1;
      sent = src_data; sv = src_valid;
      tick();
      lit("s3_dv", 32'(data_valid), 32'(sv));
      if (sv) lit("s3_data", 32'(data), 32'(sent));
    end
    idle_in(); abort = 1'b1;
    tick();
    abort = 1'b0;

    // Stall in DRAIN until timeout
    n_ad = 0;
    launch(8'd1);
    for (int i = 0; i < 16; i++) begin fir_valid = 1'b1; tick(); end
    idle_in();
    lit("s4_busy_drain", 32'(busy), 1);
    k = 0;
    while (!err && k < 400) begin tick(); k++; end
    lit("s4_err", 32'(err), 1);
    lit("s4_idle_cycles", 32'(k), 255);
    lit("s4_busy", 32'(busy), 0);
    lit("s4_no_all_done", 32'(n_ad), 0);
    launch(8'd0);
    lit("s4_err_cleared", 32'(err), 0);
    tick();

    // Abort mid-STREAM
    launch(8'd3);
    for (int i = 0; i < 20; i++) begin
      fir_valid = 1'b1; done = (i == 5); freq = 4'd7;
      tick();
    end
    idle_in(); src_valid = 1'b1;
    #1 lit("s5_ready_pre", 32'(src_ready), 1);
    abort = 1'b1;
    #1 lit("s5_ready_abort", 32'(src_ready), 0);
    tick();
    idle_in();
    lit("s5_busy", 32'(busy), 0);
    lit("s5_frames_held", 32'(frames_done), 1);
    tick();
    lit("s5_freq_held", 32'(freq_out), 7);

    // frames_done saturation
    launch(8'd255);
    for (int i = 0; i < 300; i++) begin done = 1'b1; freq = 4'($urandom); tick(); end
    done = 1'b0;
    lit("s6_saturate", 32'(frames_done), 255);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 19) == 0);
      num_frames = 8'($urandom_range(0, 3));
      abort      = ($urandom_range(0, 149) == 0);
      src_valid  = 1'($urandom_range(0, 1));
      src_data   = 16'($urandom);
      fir_valid  = ($urandom_range(0, 3) != 0);
      fft_valid  = 1'($urandom_range(0, 1));
      done       = ($urandom_range(0, 15) == 0);
      freq       = 4'($urandom);
      tick();
    end
    idle_in(); abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Reset asserted mid-DRAIN
    launch(8'd1);
    src_valid = 1'b1; src_data = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin fir_valid = 1'b1; tick(); end
    idle_in();
    tick();
    lit("s8_busy_drain", 32'(busy), 1);
    lit("s8_data", 32'(data), 32'h0000_BEEF);
    #2 rst = 1'b0;
    #1;
    lit("s8_busy", 32'(busy), 0);
    lit("s8_data_zero", 32'(data), 0);
    lit("s8_freq_out", 32'(freq_out), 0);
    lit("s8_src_ready", 32'(src_ready), 0);
    lit("s8_dv", 32'(data_valid), 0);
    @(negedge clk);
    rst = 1'b1; src_valid = 1'b1;
    tick();
    lit("s8_no_spurious_dv", 32'(data_valid), 0);
    lit("s8_idle", 32'(busy), 0);
    idle_in();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
